vpe_requant_pipe: RTL

Multi-lane, pipelined successor to the VPU single-lane combinational dequantizer. Per lane, it converts PSUM_WIDTH signed partial sums to O_WIDTH signed outputs using a per-lane FP32 scale, optional ReLU and a global output zero-point, with saturation. Sits between the systolic-array psum drain and the VPU writeback. Uses a valid/ready stream with whole-pipe stall and a register-write config port.

---
 rtl/vpu_pkg.sv | 23 ++
 rtl/vpe_requant_pipe_if.sv | 26 ++
 rtl/vpe_requant_lane.sv | 127 ++++++++++++
 rtl/vpe_requant_pipe.sv | 74 +++++++
 4 files changed

// File: rtl/vpu_pkg.sv
// Shared types and FP32 constants for the VPE requantisation pipeline.
package vpu_pkg;

  typedef enum logic [1:0] {
    RQ_CLIP       = 2'b00,
    RQ_SCALE      = 2'b01,
    RQ_SCALE_RELU = 2'b10
  } requant_mode_e;

  localparam int          FP32_EXP_BIAS_SHIFT = 150;
  localparam logic [31:0] FP32_ONE            = 32'h3F80_0000;
  localparam logic [7:0]  FP32_EXP_SPECIAL    = 8'hFF;

  // The unused encoding 2'b11 behaves as plain scaling.
  function automatic requant_mode_e decode_mode(input logic [1:0] m);
    case (m)
      2'b00:   return RQ_CLIP;
      2'b10:   return RQ_SCALE_RELU;
      default: return RQ_SCALE;
    endcase
  endfunction

endpackage

// File: rtl/vpe_requant_pipe_if.sv
// Input/output stream bundle of the requant pipe; master is the producer/consumer side.
interface vpe_requant_pipe_if #(
  parameter int LANES      = 4,
  parameter int PSUM_WIDTH = 32,
  parameter int O_WIDTH    = 8
) ();

  logic                          in_valid;
  logic                          in_ready;
  logic [1:0]                    in_mode;
  logic [LANES*PSUM_WIDTH-1:0]   in_data;
  logic                          out_valid;
  logic                          out_ready;
  logic [LANES*O_WIDTH-1:0]      out_data;

  modport master (
    output in_valid, in_mode, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_mode, in_data, out_ready,
    output in_ready, out_valid, out_data
  );

endinterface

// File: rtl/vpe_requant_lane.sv
// One lane of the requant datapath: S1 magnitude*mantissa, S2 shift/round/clamp,
// S3 ReLU, zero-point and output saturation. All stages advance together on en_i.
module vpe_requant_lane
  import vpu_pkg::*;
#(
  parameter int PSUM_WIDTH = 32,
  parameter int O_WIDTH    = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         en_i,
  input  logic signed [PSUM_WIDTH-1:0] x_i,
  input  logic [31:0]                  scale_i,
  input  logic signed [O_WIDTH-1:0]    zp_i,
  input  requant_mode_e                mode_i,
  output logic signed [O_WIDTH-1:0]    out_o
);

  localparam int PROD_W = PSUM_WIDTH + 24;
  localparam int SH_W   = $clog2(PROD_W);
  localparam int V_W    = O_WIDTH + 2;
  localparam int W_W    = O_WIDTH + 3;

  localparam logic [PROD_W:0]                R_MAX   = (PROD_W+1)'(2**O_WIDTH);
  localparam logic signed [PSUM_WIDTH-1:0]   CLIP_HI = PSUM_WIDTH'(2**O_WIDTH);
  localparam logic signed [PSUM_WIDTH-1:0]   CLIP_LO = PSUM_WIDTH'(-(2**O_WIDTH));
  localparam logic signed [W_W-1:0]          OUT_MAX = W_W'(2**(O_WIDTH-1) - 1);
  localparam logic signed [W_W-1:0]          OUT_MIN = W_W'(-(2**(O_WIDTH-1)));

  // S1
  logic [PSUM_WIDTH-1:0]        mag;
  logic [7:0]                   exp_c;
  logic [PROD_W-1:0]            prod_d, prod_q;
  logic signed [9:0]            shamt_d, shamt_q;
  logic                         fsign_d, fsign_q;
  logic                         zero_d, zero_q;
  logic                         special_d, special_q;
  logic signed [PSUM_WIDTH-1:0] x_q;
  requant_mode_e                mode1_q, mode2_q;
  logic signed [O_WIDTH-1:0]    zp1_q, zp2_q;

  always_comb begin
    mag       = x_i[PSUM_WIDTH-1] ? (~$unsigned(x_i) + 1'b1) : $unsigned(x_i);
    exp_c     = scale_i[30:23];
    prod_d    = PROD_W'(mag) * PROD_W'({1'b1, scale_i[22:0]});
    shamt_d   = 10'(FP32_EXP_BIAS_SHIFT) - $signed({2'b00, exp_c});
    fsign_d   = x_i[PSUM_WIDTH-1] ^ scale_i[31];
    zero_d    = (x_i == '0) || (exp_c == 8'h00);
    special_d = (exp_c == FP32_EXP_SPECIAL);
  end

  // NOTE: non-blocking (<=) so each stage samples its neighbour's pre-edge value.
  // NOTE: datapath registers carry no reset; the top's valid bits qualify them.
  always_ff @(posedge clk) begin
    if (en_i) begin
      prod_q    <= prod_d;
      shamt_q   <= shamt_d;
      fsign_q   <= fsign_d;
      zero_q    <= zero_d;
      special_q <= special_d;
      x_q       <= x_i;
      mode1_q   <= mode_i;
      zp1_q     <= zp_i;
    end
  end

  // S2
  logic [SH_W-1:0]       sh;
  logic [PROD_W-1:0]     shifted;
  logic                  rnd;
  logic [PROD_W:0]       r;
  logic signed [V_W-1:0] v_d, v_q;

  always_comb begin
    // NOTE: defaults first so no branch leaves a variable unassigned (no latches).
    r       = '0;
    v_d     = '0;
    sh      = shamt_q[SH_W-1:0];
    shifted = prod_q >> sh;
    rnd     = (sh != '0) ? prod_q[sh - 1'b1] : 1'b0;
    if (zero_q) begin
      r = '0;
    end else if (special_q || shamt_q[9]) begin
      r = R_MAX;
    end else if (shamt_q < $signed(10'(PROD_W))) begin
      r = {1'b0, shifted} + {{PROD_W{1'b0}}, rnd};
    end
    if (r > R_MAX) r = R_MAX;

    if (mode1_q == RQ_CLIP) begin
      if (x_q > CLIP_HI)      v_d = CLIP_HI[V_W-1:0];
      else if (x_q < CLIP_LO) v_d = CLIP_LO[V_W-1:0];
      else                    v_d = x_q[V_W-1:0];
    end else begin
      v_d = fsign_q ? -$signed({1'b0, r[O_WIDTH:0]}) : $signed({1'b0, r[O_WIDTH:0]});
    end
  end

  always_ff @(posedge clk) begin
    if (en_i) begin
      v_q     <= v_d;
      mode2_q <= mode1_q;
      zp2_q   <= zp1_q;
    end
  end

  // S3
  logic signed [V_W-1:0]     v_relu;
  logic signed [W_W-1:0]     w;
  logic signed [O_WIDTH-1:0] out_d, out_q;

  always_comb begin
    v_relu = (mode2_q == RQ_SCALE_RELU && v_q[V_W-1]) ? '0 : v_q;
    w      = W_W'(v_relu) + W_W'(zp2_q);
    if (w > OUT_MAX)      out_d = OUT_MAX[O_WIDTH-1:0];
    else if (w < OUT_MIN) out_d = OUT_MIN[O_WIDTH-1:0];
    else                  out_d = w[O_WIDTH-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst)       out_q <= '0;
    else if (en_i) out_q <= out_d;
  end

  assign out_o = out_q;

endmodule

// File: rtl/vpe_requant_pipe.sv
// Multi-lane requant pipe: shared valid/ready with whole-pipe stall, per-lane FP32
// scale registers and a global output zero-point, written through a small config port.
module vpe_requant_pipe
  import vpu_pkg::*;
#(
  parameter int LANES      = 4,
  parameter int PSUM_WIDTH = 32,
  parameter int O_WIDTH    = 8,
  parameter int CFG_AW     = $clog2(LANES+1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_we,
  input  logic [CFG_AW-1:0] cfg_addr,
  input  logic [31:0]       cfg_wdata,
  vpe_requant_pipe_if.slave bus
);

  logic [2:0]                     valid_d, valid_q;
  logic                           stall, accept, stage_en;
  logic [31:0]                    scale_q [LANES];
  logic signed [O_WIDTH-1:0]      zp_q;
  requant_mode_e                  mode_c;
  logic [LANES-1:0][O_WIDTH-1:0]  lane_out;

  assign stall         = valid_q[2] && !bus.out_ready;
  assign stage_en      = !stall;
  assign accept        = bus.in_valid && stage_en;
  assign bus.in_ready  = stage_en;
  assign bus.out_valid = valid_q[2];
  assign bus.out_data  = lane_out;
  assign mode_c        = decode_mode(bus.in_mode);

  // Bubbles shift through like beats; nothing is compressed.
  always_comb begin
    valid_d = valid_q;
    if (stage_en) valid_d = {valid_q[1:0], accept};
  end

  always_ff @(posedge clk) begin
    if (rst) valid_q <= '0;
    else     valid_q <= valid_d;
  end

  // Scales feed S1 directly, so a beat accepted alongside a write sees the old value.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < LANES; i++) scale_q[i] <= FP32_ONE;
      zp_q <= '0;
    end else if (cfg_we) begin
      for (int i = 0; i < LANES; i++) begin
        if (cfg_addr == CFG_AW'(i)) scale_q[i] <= cfg_wdata;
      end
      if (cfg_addr == CFG_AW'(LANES)) zp_q <= cfg_wdata[O_WIDTH-1:0];
    end
  end

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    vpe_requant_lane #(
      .PSUM_WIDTH(PSUM_WIDTH),
      .O_WIDTH   (O_WIDTH)
    ) u_lane (
      .clk    (clk),
      .rst    (rst),
      .en_i   (stage_en),
      .x_i    (bus.in_data[g*PSUM_WIDTH +: PSUM_WIDTH]),
      .scale_i(scale_q[g]),
      .zp_i   (zp_q),
      .mode_i (mode_c),
      .out_o  (lane_out[g])
    );
  end

endmodule
